// File: rtl/div_pkg.sv
// Shared definitions for the divide-controller slice: funct3 encodings, FSM states
// and the fixed results used by the bypass paths.
package div_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling around an unsigned divider: operand magnitudes on the way in,
// quotient/remainder negation on the way out. Signed logic exists only with DIVCTL_SIGNED_EN.
module div_sign_fix (
  input  logic        op_signed,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] a_mag,
  output logic [31:0] b_mag,
  output logic        neg_quot,
  output logic        neg_rem,
  input  logic [31:0] raw_quot,
  input  logic [31:0] raw_rem,
  input  logic        fix_quot,
  input  logic        fix_rem,
  output logic [31:0] quot,
  output logic [31:0] rem
);

`ifdef DIVCTL_SIGNED_EN
  always_comb begin
    a_mag    = (op_signed && rs1[31]) ? -rs1 : rs1;
    b_mag    = (op_signed && rs2[31]) ? -rs2 : rs2;
    // Quotient sign follows the operand sign difference; remainder follows the dividend.
    neg_quot = op_signed && (rs1[31] ^ rs2[31]);
    neg_rem  = op_signed && rs1[31];
    quot     = fix_quot ? -raw_quot : raw_quot;
    rem      = fix_rem ? -raw_rem : raw_rem;
  end
`else
  logic unused_sign;

  assign a_mag       = rs1;
  assign b_mag       = rs2;
  assign neg_quot    = 1'b0;
  assign neg_rem     = 1'b0;
  assign quot        = raw_quot;
  assign rem         = raw_rem;
  assign unused_sign = ^{op_signed, fix_quot, fix_rem};
`endif

endmodule

// File: rtl/div_ctrl.sv
// Request/response shell around an iterative divider with bypass, timeout and flush.
// Build option DIVCTL_SIGNED_EN: when defined DIV/REM are signed, otherwise they act as DIVU/REMU.
module div_ctrl
  import div_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             div_start,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  input  logic [31:0]      div_d,
  input  logic [31:0]      div_r,
  input  logic             div_ok,
  input  logic             div_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             rem_op_q, rem_op_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;

  logic        req_signed, div_zero, overflow, bypass, accept, timeout;
  logic        op_neg_quot, op_neg_rem;
  logic [31:0] a_mag, b_mag, quot_fix, rem_fix;

`ifdef DIVCTL_SIGNED_EN
  assign req_signed = is_signed_op(req_funct3);
  assign overflow   = req_signed && (req_rs1 == INT_MIN) && (req_rs2 == 32'hFFFF_FFFF);
`else
  assign req_signed = 1'b0;
  assign overflow   = 1'b0;
`endif

  assign div_zero = (req_rs2 == 32'd0);
  assign bypass   = div_zero || overflow;
  assign accept   = (state_q == S_IDLE) && req_valid && !flush;
  assign timeout  = (cnt_q == CNT_LAST);

  div_sign_fix u_sign_fix (
    .op_signed (req_signed),
    .rs1       (req_rs1),
    .rs2       (req_rs2),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .neg_quot  (op_neg_quot),
    .neg_rem   (op_neg_rem),
    .raw_quot  (div_d),
    .raw_rem   (div_r),
    .fix_quot  (neg_quot_q),
    .fix_rem   (neg_rem_q),
    .quot      (quot_fix),
    .rem       (rem_fix)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every variable gets a default first so no latch is inferred on untaken paths.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = bypass ? S_RESP : S_BUSY;
      S_BUSY: begin
        if (flush)                               state_d = S_IDLE;
        else if (div_ok || div_err || timeout)   state_d = S_RESP;
      end
      S_RESP: if (flush || rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    div_start = (state_q == S_BUSY);
    rsp_valid = (state_q == S_RESP);
  end

  always_comb begin
    tag_d      = tag_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_op_d   = rem_op_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    err_d      = err_q;
    if (accept) begin
      tag_d      = req_tag;
      a_d        = a_mag;
      b_d        = b_mag;
      rem_op_d   = is_rem(req_funct3);
      neg_quot_d = op_neg_quot;
      neg_rem_d  = op_neg_rem;
      cnt_d      = '0;
      err_d      = 1'b0;
      // Bypass results are final here; divider-bound requests overwrite data_d later.
      if (div_zero) data_d = is_rem(req_funct3) ? req_rs1 : DIV0_QUOT;
      else          data_d = is_rem(req_funct3) ? 32'd0 : INT_MIN;
    end else if ((state_q == S_BUSY) && !flush) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_err) begin
        data_d = 32'd0;
        err_d  = 1'b1;
      end else if (div_ok) begin
        data_d = rem_op_q ? rem_fix : quot_fix;
      end else if (timeout) begin
        data_d = 32'd0;
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_op_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_op_q   <= rem_op_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign div_a    = a_q;
  assign div_b    = b_q;
  assign rsp_data = data_q;
  assign rsp_tag  = tag_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed vector table, hand-written flush/reset/handshake
// sequences and randomized operations against a plain-arithmetic reference model.
module tb_div_ctrl;
  import div_pkg::*;

  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 64;
`ifdef DIVCTL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_funct3 = F3_DIVU;
  logic [31:0]      req_rs1 = '0;
  logic [31:0]      req_rs2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             flush = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             div_start;
  logic [31:0]      div_a, div_b;
  logic [31:0]      div_d = '0;
  logic [31:0]      div_r = '0;
  logic             div_ok = 1'b0;
  logic             div_err = 1'b0;

  int errors = 0;
  int checks = 0;

  div_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_tag    (req_tag),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_d      (div_d),
    .div_r      (div_r),
    .div_ok     (div_ok),
    .div_err    (div_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          lat;     // divider cycles before answering; negative never answers
    int          rk;      // 0 ok, 1 ok+err, 2 err only
    logic [31:0] exp_data;
    logic        exp_err;
    bit          exp_byp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit op_signed(input logic [2:0] f3);
    return SIGNED_EN && ((f3 == F3_DIV) || (f3 == F3_REM));
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input bit sg);
    if (sg && v[31]) return 32'(-longint'($signed(v)));
    return v;
  endfunction

  function automatic bit ref_bypass(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2);
    return (rs2 == 32'd0) || (op_signed(f3) && rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF);
  endfunction

  // Architectural result using native arithmetic; signed overflow falls out of 64-bit math.
  function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2);
    bit     rem;
    longint sa, sb;
    rem = (f3 == F3_REM) || (f3 == F3_REMU);
    if (rs2 == 32'd0) return rem ? rs1 : 32'hFFFF_FFFF;
    if (op_signed(f3)) begin
      sa = longint'($signed(rs1));
      sb = longint'($signed(rs2));
      return rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rem ? (rs1 % rs2) : (rs1 / rs2);
  endfunction

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [TAG_W-1:0] tag, input int lat,
                        input int rk, input int hold, input logic [31:0] exp_data,
                        input logic exp_err, input bit exp_byp);
    bit          sg, got;
    int          starts, t, exp_starts;
    logic [31:0] exp_a, exp_b;
    sg         = op_signed(f3);
    exp_a      = mag(rs1, sg);
    exp_b      = mag(rs2, sg);
    exp_starts = exp_byp ? 0 : ((lat < 0) ? TIMEOUT : lat);

    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_tag    = tag;
    @(negedge clk);
    check($sformatf("%s.req_ready", nm), req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_rs1   = $urandom;
    req_rs2   = $urandom;
    req_tag   = TAG_W'($urandom);

    starts = 0;
    t      = 0;
    got    = 1'b0;
    while (!got && t < TIMEOUT + 20) begin
      @(negedge clk);
      t++;
      div_ok  = 1'b0;
      div_err = 1'b0;
      div_d   = $urandom;
      div_r   = $urandom;
      if (rsp_valid) got = 1'b1;
      else if (div_start) begin
        starts++;
        if (starts == 1) begin
          check($sformatf("%s.div_a", nm), div_a, exp_a);
          check($sformatf("%s.div_b", nm), div_b, exp_b);
        end
        if (lat >= 0 && starts == lat) begin
          div_d   = (div_b != 0) ? div_a / div_b : 32'hFFFF_FFFF;
          div_r   = (div_b != 0) ? div_a % div_b : div_a;
          div_ok  = (rk != 2);
          div_err = (rk != 0);
        end
      end
    end
    check($sformatf("%s.rsp_seen", nm), 32'(got), 1);
    check($sformatf("%s.start_cycles", nm), starts, exp_starts);
    check($sformatf("%s.latency", nm), t, exp_starts + 1);
    check($sformatf("%s.data", nm), rsp_data, exp_data);
    check($sformatf("%s.tag", nm), rsp_tag, tag);
    check($sformatf("%s.err", nm), rsp_err, exp_err);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("%s.hold%0d.valid", nm, h), rsp_valid, 1);
      check($sformatf("%s.hold%0d.data", nm, h), rsp_data, exp_data);
      check($sformatf("%s.hold%0d.tag", nm, h), rsp_tag, tag);
      check($sformatf("%s.hold%0d.err", nm, h), rsp_err, exp_err);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check($sformatf("%s.done_valid", nm), rsp_valid, 0);
    check($sformatf("%s.done_ready", nm), req_ready, 1);
  endtask

  vec_t        vecs[$];
  logic [2:0]  f3;
  logic [31:0] rs1, rs2, ed;
  logic        ee;
  bit          byp;
  int          lat, rk;

  initial begin
    vecs.push_back('{F3_DIVU, 32'd1023, 32'd50, 3, 0, 32'd20, 1'b0, 1'b0});
    vecs.push_back('{F3_REMU, 32'd1023, 32'd50, 1, 0, 32'd23, 1'b0, 1'b0});
    vecs.push_back('{F3_DIV, 32'hFFFF_FFF9, 32'd2, 2, 0, SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 1'b0, 1'b0});
    vecs.push_back('{F3_REM, 32'hFFFF_FFF9, 32'd2, 4, 0, SIGNED_EN ? 32'hFFFF_FFFF : 32'd1, 1'b0, 1'b0});
    vecs.push_back('{F3_DIVU, 32'd5, 32'd0, 1, 0, 32'hFFFF_FFFF, 1'b0, 1'b1});
    vecs.push_back('{F3_REMU, 32'd5, 32'd0, 1, 0, 32'd5, 1'b0, 1'b1});
    vecs.push_back('{F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0, SIGNED_EN ? 32'h8000_0000 : 32'd0, 1'b0, SIGNED_EN});
    vecs.push_back('{F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0, SIGNED_EN ? 32'd0 : 32'h8000_0000, 1'b0, SIGNED_EN});
    vecs.push_back('{F3_DIV, 32'd100, 32'hFFFF_FFF9, 1, 0, SIGNED_EN ? 32'hFFFF_FFF2 : 32'd0, 1'b0, 1'b0});
    vecs.push_back('{F3_REM, 32'd100, 32'hFFFF_FFF9, 3, 0, SIGNED_EN ? 32'd2 : 32'd100, 1'b0, 1'b0});
    vecs.push_back('{F3_DIVU, 32'd1023, 32'd50, 2, 1, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{F3_REMU, 32'd9, 32'd4, 3, 2, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{F3_DIVU, 32'd1023, 32'd50, -1, 0, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{F3_REM, 32'hFFFF_FFF9, 32'd0, 1, 0, 32'hFFFF_FFF9, 1'b0, 1'b1});
    vecs.push_back('{F3_DIVU, 32'hFFFF_FFFF, 32'd1, 1, 0, 32'hFFFF_FFFF, 1'b0, 1'b0});

    // Reset values
    #12;
    check("reset.req_ready", req_ready, 1);
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.div_start", div_start, 0);
    check("reset.rsp_data", rsp_data, 0);
    check("reset.rsp_tag", rsp_tag, 0);
    check("reset.rsp_err", rsp_err, 0);
    check("reset.div_a", div_a, 0);
    check("reset.div_b", div_b, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("v%0d", i), vecs[i].f3, vecs[i].rs1, vecs[i].rs2, TAG_W'(i), vecs[i].lat,
             vecs[i].rk, (i == 0) ? 5 : i % 3, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_byp);

    // Flush three cycles into BUSY
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = F3_DIVU; req_rs1 = 32'd1023; req_rs2 = 32'd50; req_tag = 5'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("flush_busy.start%0d", c), div_start, 1);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("flush_busy.after%0d.valid", c), rsp_valid, 0);
      check($sformatf("flush_busy.after%0d.start", c), div_start, 0);
      check($sformatf("flush_busy.after%0d.ready", c), req_ready, 1);
    end

    // Flush while a response is pending drops it
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = F3_DIVU; req_rs1 = 32'd5; req_rs2 = 32'd0; req_tag = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("flush_resp.valid_before", rsp_valid, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_resp.valid_after", rsp_valid, 0);
    check("flush_resp.ready_after", req_ready, 1);

    // Flush wins over a same-cycle request
    @(posedge clk); #1;
    req_valid = 1'b1; flush = 1'b1; req_funct3 = F3_DIVU; req_rs1 = 32'd5; req_rs2 = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_req.valid", rsp_valid, 0);
    check("flush_req.start", div_start, 0);
    check("flush_req.ready", req_ready, 1);

    // No acceptance in the cycle a response completes
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = F3_DIVU; req_rs1 = 32'd5; req_rs2 = 32'd0; req_tag = 5'd3;
    @(posedge clk); #1;
    req_funct3 = F3_REMU; req_rs1 = 32'd6; req_tag = 5'd4; rsp_ready = 1'b1;
    @(negedge clk);
    check("b2b.first_valid", rsp_valid, 1);
    check("b2b.first_tag", rsp_tag, 3);
    check("b2b.first_ready", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("b2b.gap_valid", rsp_valid, 0);
    check("b2b.gap_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b.second_valid", rsp_valid, 1);
    check("b2b.second_tag", rsp_tag, 4);
    check("b2b.second_data", rsp_data, 6);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Asynchronous reset in the middle of BUSY
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = F3_DIVU; req_rs1 = 32'd1023; req_rs2 = 32'd50; req_tag = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_busy.start_before", div_start, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_busy.start_now", div_start, 0);
    check("rst_busy.ready_now", req_ready, 1);
    check("rst_busy.data_now", rsp_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_busy.after%0d.valid", c), rsp_valid, 0);
      check($sformatf("rst_busy.after%0d.start", c), div_start, 0);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      f3  = {1'b1, 2'($urandom_range(0, 3))};
      rs1 = $urandom;
      rs2 = $urandom;
      case ($urandom_range(0, 7))
        0: rs2 = 32'd0;
        1: begin rs1 = 32'h8000_0000; rs2 = 32'hFFFF_FFFF; end
        2: rs2 = $urandom_range(1, 16);
        3: rs1 = $urandom_range(0, 1000);
        default: ;
      endcase
      lat = $urandom_range(1, 6);
      rk  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      byp = ref_bypass(f3, rs1, rs2);
      ee  = (rk != 0) && !byp;
      ed  = ee ? 32'd0 : ref_data(f3, rs1, rs2);
      run_op($sformatf("r%0d", i), f3, rs1, rs2, TAG_W'(i), lat, rk, $urandom_range(0, 2), ed, ee, byp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
